ising_run_ctrl: RTL
===================

ISING_RUN_CTRL -- requirements
Module: ising_run_ctrl

Interface
REQ-001 Parameters SHALL be:
- N_SPINS, default 8: number of spin phase inputs.
- CNT_W, default 32: width of the cycle counters.
- SYNC_STAGES, default 2: synchronizer depth, minimum 2.

REQ-002 Ports SHALL be:
- clk, in, 1: sole clock.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: run request, one-cycle pulse or level.
- abort, in, 1: cancels the current run.
- cfg_hold_cycles, in, CNT_W: cycles ising_rstn stays low before release.
- cfg_run_cycles, in, CNT_W: anneal duration.
- phase_in, in, N_SPINS: asynchronous oscillator phases.
- ising_rstn, out, 1: array enable, low = oscillators held.
- busy, out, 1: a run is in progress.
- res_valid, out, 1: result handshake valid.
- res_ready, in, 1: result handshake ready.
- res_spins, out, N_SPINS: sampled spin vector.
- run_count, out, 16: completed runs, wraps.

Function
REQ-003 The FSM SHALL have the states IDLE, HOLD, RUN, SAMPLE and RESULT, encoded in the shared package.
REQ-004 IDLE: ising_rstn=0, busy=0; start=1 SHALL enter HOLD next cycle, latching both cfg values and clearing the counter.
REQ-005 HOLD: ising_rstn=0 for exactly max(cfg_hold_cycles,1) cycles, then SHALL enter RUN.
REQ-006 RUN: ising_rstn=1 for exactly cfg_run_cycles cycles; a value of 0 SHALL skip RUN and go directly to SAMPLE.
REQ-007 SAMPLE: ising_rstn SHALL remain 1; after SYNC_STAGES cycles, res_spins SHALL capture the synchronized phase_in, then the FSM SHALL enter RESULT.
REQ-008 RESULT: ising_rstn=0, res_valid=1, res_spins stable; on res_valid&&res_ready the FSM SHALL return to IDLE next cycle and increment run_count (wrap 0xFFFF->0).
REQ-009 busy SHALL equal 1 in HOLD, RUN and SAMPLE only.
REQ-010 start outside IDLE SHALL be ignored; start in the same cycle as a RESULT handshake SHALL be ignored (IDLE is required first).
REQ-011 abort in HOLD/RUN/SAMPLE SHALL force IDLE next cycle with ising_rstn=0, no result, and run_count unchanged; abort in RESULT SHALL drop res_valid and return to IDLE without incrementing.
REQ-012 abort and start asserted together in IDLE: abort SHALL win and the FSM stays in IDLE.
REQ-013 phase_in SHALL pass through a SYNC_STAGES-deep flop synchronizer per bit before any use.
REQ-014 Counters SHALL compare at CNT_W bits with no overflow; cfg changes during a run SHALL have no effect.
REQ-015 ising_rstn SHALL be driven directly from a flop (glitch-free).

Reset
REQ-016 On rst: state=IDLE, ising_rstn=0, busy=0, res_valid=0, res_spins=0, run_count=0, synchronizers=0, counters=0.
REQ-017 rst asserted mid-run SHALL immediately drop ising_rstn, with no result produced.

Configuration
REQ-018 The macro ISING_MAJORITY_SAMPLE_EN SHALL select the sampling mode:
- Defined: SAMPLE takes 3 synchronized snapshots spaced 4 cycles apart (first at SYNC_STAGES, then +4, +8); res_spins is the per-bit majority of the three; SAMPLE lasts SYNC_STAGES+9 cycles.
- Undefined: single snapshot per REQ-007; the majority logic is absent.

Structure
REQ-019 Package ising_ctrl_pkg SHALL hold the state enum typedef, the snapshot spacing constant (4) and the run_count width (16).
REQ-020 Sub-module ising_phase_sync (parameterized N_SPINS-wide, SYNC_STAGES-deep synchronizer) SHALL be instantiated once.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Basic run: hold=3, run=10, start pulse -> ising_rstn low 3 cycles, high 10+SYNC_STAGES cycles; res_valid with res_spins = phase_in value held constant 0xA5; run_count=1 after ready.
- Zero run: hold=0, run=0 -> 1 hold cycle, then direct to SAMPLE; result valid.
- Backpressure: res_ready held low 20 cycles -> res_valid stays 1, res_spins stable, ising_rstn=0; handshake then completes.
- Abort in RUN at cycle 5 -> next cycle IDLE, ising_rstn=0, no res_valid, run_count unchanged; start+abort together in IDLE -> stays IDLE.
- Async reset mid-RUN -> ising_rstn=0 the same cycle; all outputs at reset values.
- With ISING_MAJORITY_SAMPLE_EN: bit0 toggled 1,0,1 across the three snapshots -> res_spins[0]=1; bit1 0,1,0 -> 0.

Source files
------------

// File: rtl/ising_ctrl_pkg.sv
// Shared definitions for the Ising array run controller: FSM state encoding,
// majority-snapshot spacing and the completed-run counter width.
package ising_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HOLD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_RESULT = 3'd4
  } state_e;

  localparam int unsigned SNAP_SPACING = 4;
  localparam int unsigned RUN_COUNT_W  = 16;

endpackage

// File: rtl/ising_phase_sync.sv
// Per-bit multi-flop synchronizer bringing the free-running oscillator phases
// into the clk domain; all stages clear on reset.
module ising_phase_sync #(
  parameter int N_SPINS     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SPINS-1:0] d,
  output logic [N_SPINS-1:0] q
);

  logic [N_SPINS-1:0] stage_q [SYNC_STAGES];
  logic [N_SPINS-1:0] stage_d [SYNC_STAGES];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/ising_run_ctrl.sv
// Sequences one anneal run of the oscillator array: hold, run, sample, result.
// Define ISING_MAJORITY_SAMPLE_EN to take a 3-snapshot per-bit majority vote.
module ising_run_ctrl
  import ising_ctrl_pkg::*;
#(
  parameter int N_SPINS     = 8,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CNT_W-1:0]       cfg_hold_cycles,
  input  logic [CNT_W-1:0]       cfg_run_cycles,
  input  logic [N_SPINS-1:0]     phase_in,
  output logic                   ising_rstn,
  output logic                   busy,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [N_SPINS-1:0]     res_spins,
  output logic [RUN_COUNT_W-1:0] run_count
);

  // Result handshake: res_valid is high only in RESULT and res_spins is frozen
  // there; the transfer happens on any cycle with res_valid && res_ready.
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] SNAP0_AT   = CNT_W'(SYNC_STAGES);
`ifdef ISING_MAJORITY_SAMPLE_EN
  localparam logic [CNT_W-1:0] SNAP1_AT   = CNT_W'(SYNC_STAGES + SNAP_SPACING);
  localparam logic [CNT_W-1:0] SNAP2_AT   = CNT_W'(SYNC_STAGES + 2 * SNAP_SPACING);
  localparam logic [CNT_W-1:0] SAMPLE_END = CNT_W'(SYNC_STAGES + 2 * SNAP_SPACING + 1);
`else
  localparam logic [CNT_W-1:0] SAMPLE_END = SNAP0_AT;
`endif

  logic [N_SPINS-1:0] sync_phase;

  ising_phase_sync #(
    .N_SPINS    (N_SPINS),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_phase_sync (
    .clk(clk),
    .rst(rst),
    .d  (phase_in),
    .q  (sync_phase)
  );

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       hold_q, hold_d;
  logic [CNT_W-1:0]       run_q, run_d;
  logic [N_SPINS-1:0]     spins_q, spins_d;
  logic [RUN_COUNT_W-1:0] run_count_q, run_count_d;
  logic                   rstn_q, rstn_d;
  logic                   busy_q, busy_d;
  logic                   valid_q, valid_d;
`ifdef ISING_MAJORITY_SAMPLE_EN
  logic [N_SPINS-1:0]     snap0_q, snap0_d;
  logic [N_SPINS-1:0]     snap1_q, snap1_d;
  logic [N_SPINS-1:0]     snap2_q, snap2_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    run_d       = run_q;
    spins_d     = spins_q;
    run_count_d = run_count_q;
`ifdef ISING_MAJORITY_SAMPLE_EN
    snap0_d     = snap0_q;
    snap1_d     = snap1_q;
    snap2_d     = snap2_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_HOLD;
          hold_d  = cfg_hold_cycles;
          run_d   = cfg_run_cycles;
          cnt_d   = CNT_ONE;
        end
      end
      // cnt_q is 1-based so a >= compare covers hold=0 and never overflows.
      ST_HOLD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q >= hold_q) begin
          state_d = (run_q == '0) ? ST_SAMPLE : ST_RUN;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q >= run_q) begin
          state_d = ST_SAMPLE;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
`ifdef ISING_MAJORITY_SAMPLE_EN
          if (cnt_q == SNAP0_AT) snap0_d = sync_phase;
          if (cnt_q == SNAP1_AT) snap1_d = sync_phase;
          if (cnt_q == SNAP2_AT) snap2_d = sync_phase;
          if (cnt_q == SAMPLE_END) begin
            state_d = ST_RESULT;
            spins_d = (snap0_q & snap1_q) | (snap0_q & snap2_q) | (snap1_q & snap2_q);
          end
`else
          if (cnt_q == SAMPLE_END) begin
            state_d = ST_RESULT;
            spins_d = sync_phase;
          end
`endif
        end
      end
      ST_RESULT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (res_ready) begin
          state_d     = ST_IDLE;
          run_count_d = run_count_q + RUN_COUNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so ising_rstn is a clean flop.
    rstn_d  = (state_d == ST_RUN) || (state_d == ST_SAMPLE);
    busy_d  = (state_d == ST_HOLD) || (state_d == ST_RUN) || (state_d == ST_SAMPLE);
    valid_d = (state_d == ST_RESULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      run_q       <= '0;
      spins_q     <= '0;
      run_count_q <= '0;
      rstn_q      <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
`ifdef ISING_MAJORITY_SAMPLE_EN
      snap0_q     <= '0;
      snap1_q     <= '0;
      snap2_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      run_q       <= run_d;
      spins_q     <= spins_d;
      run_count_q <= run_count_d;
      rstn_q      <= rstn_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
`ifdef ISING_MAJORITY_SAMPLE_EN
      snap0_q     <= snap0_d;
      snap1_q     <= snap1_d;
      snap2_q     <= snap2_d;
`endif
    end
  end

  assign ising_rstn = rstn_q;
  assign busy       = busy_q;
  assign res_valid  = valid_q;
  assign res_spins  = spins_q;
  assign run_count  = run_count_q;

endmodule
